// File: rtl/spad_rf_pkg.sv
// Shared types and defaults for the PE scratchpad register file.
// Holds the clear-engine state type and the port packing helper.
package spad_rf_pkg;

   localparam int unsigned DefDataBitwidth = 8;
   localparam int unsigned DefAddrBitwidth = 4;
   localparam int unsigned DefNumRd        = 2;

   typedef enum logic [0:0] {
      IDLE,
      CLEAR
   } clr_state_t;

   // Low bit of port k's field inside a packed multi-port bus.
   function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/spad_rf_clear_ctrl.sv
// Bulk-clear sequencer: walks every address once, issuing a zero write per cycle.
// Busy is taken straight from the state register so it is glitch-free.
module spad_rf_clear_ctrl
   import spad_rf_pkg::*;
#(
   parameter int unsigned ADDR_BITWIDTH = DefAddrBitwidth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_start,
   output logic                     clr_busy,
   output logic                     clr_we,
   output logic [ADDR_BITWIDTH-1:0] clr_addr
);

   clr_state_t               state_q, state_d;
   logic [ADDR_BITWIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            // clr_start is deliberately not looked at here.
            if (cnt_q == {ADDR_BITWIDTH{1'b1}}) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clr_busy = (state_q == CLEAR);
      clr_we   = (state_q == CLEAR);
      clr_addr = cnt_q;
   end

endmodule

// File: rtl/spad_register_file.sv
// Multi-read-port scratchpad with accumulate-on-write, write-first bypass and
// a sequenced bulk clear. Reads are registered; all ports share one write port.
module spad_register_file
   import spad_rf_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH = DefDataBitwidth,
   parameter int unsigned ADDR_BITWIDTH = DefAddrBitwidth,
   parameter int unsigned NUM_RD        = DefNumRd
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              we,
   input  logic                              acc,
   input  logic [ADDR_BITWIDTH-1:0]          wr_addr,
   input  logic [DATA_BITWIDTH-1:0]          din,
   input  logic [NUM_RD-1:0]                 rd_en,
   input  logic [NUM_RD*ADDR_BITWIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_BITWIDTH-1:0]   dout,
   output logic [NUM_RD-1:0]                 dout_valid,
   input  logic                              clr_start,
   output logic                              clr_busy
);

   localparam int unsigned DEPTH = 1 << ADDR_BITWIDTH;

   logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];
   logic                     clr_we;
   logic [ADDR_BITWIDTH-1:0] clr_addr;
   logic                     access;
   logic [DATA_BITWIDTH-1:0] wr_val;

   spad_rf_clear_ctrl #(
      .ADDR_BITWIDTH (ADDR_BITWIDTH)
   ) u_clear_ctrl (
      .clk       (clk),
      .rst       (rst),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // A clear request pre-empts the cycle it arrives in as well as the clear itself.
   assign access = ~clr_busy & ~clr_start;

   // Post-write value; the sum wraps at DATA_BITWIDTH.
   always_comb begin
      wr_val = din;
      if (acc) begin
         wr_val = mem_q[wr_addr] + din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (access && we) begin
         mem_q[wr_addr] <= wr_val;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int unsigned AddrLo = slice_lo(k, ADDR_BITWIDTH);
      localparam int unsigned DataLo = slice_lo(k, DATA_BITWIDTH);

      logic [ADDR_BITWIDTH-1:0] addr;
      logic [DATA_BITWIDTH-1:0] rd_val;
      logic [DATA_BITWIDTH-1:0] dout_q;
      logic                     valid_q;

      assign addr   = rd_addr[AddrLo +: ADDR_BITWIDTH];
      assign rd_val = (we && (addr == wr_addr)) ? wr_val : mem_q[addr];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= access & rd_en[k];
            if (access && rd_en[k]) begin
               dout_q <= rd_val;
            end
         end
      end

      assign dout[DataLo +: DATA_BITWIDTH] = dout_q;
      assign dout_valid[k]                 = valid_q;
   end

endmodule

// File: tb/tb_spad_register_file.sv
// Self-checking bench for spad_register_file: vector table plus clear/reset sequences,
// read expectations queued at drive time and popped when dout_valid returns.
module tb_spad_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic        acc;
   logic [3:0]  wr_addr;
   logic [7:0]  din;
   logic [1:0]  rd_en;
   logic [7:0]  rd_addr;
   logic [15:0] dout;
   logic [1:0]  dout_valid;
   logic        clr_start;
   logic        clr_busy;

   always #5 clk = ~clk;

   spad_register_file #(
      .DATA_BITWIDTH (8),
      .ADDR_BITWIDTH (4),
      .NUM_RD        (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .acc        (acc),
      .wr_addr    (wr_addr),
      .din        (din),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .clr_start  (clr_start),
      .clr_busy   (clr_busy)
   );

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic       we;
      logic       acc;
      logic [3:0] wa;
      logic [7:0] d;
      logic [1:0] re;
      logic [3:0] ra0;
      logic [3:0] ra1;
      logic [1:0] ev;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   errors = 0;
   int   checks = 0;
   int   n_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: apply inputs, queue read expectations, then compare after the edge.
   task automatic drive(input logic w, input logic a, input logic [3:0] wa, input logic [7:0] d,
                        input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic cs, input logic [1:0] ev, input logic [7:0] e0,
                        input logic [7:0] e1, input string tag);
      exp_t it;
      we        = w;
      acc       = a;
      wr_addr   = wa;
      din       = d;
      rd_en     = re;
      rd_addr   = {ra1, ra0};
      clr_start = cs;
      if (ev[0]) sb.push_back('{0, e0});
      if (ev[1]) sb.push_back('{1, e1});
      @(posedge clk);
      #1;
      check({tag, " valid"}, {30'd0, dout_valid}, {30'd0, ev});
      while (sb.size() > 0) begin
         it = sb.pop_front();
         check($sformatf("%s dout%0d", tag, it.port), {24'd0, dout[it.port*8 +: 8]},
               {24'd0, it.data});
      end
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0, tag);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b11, 4'(i), 4'(15 - i), 1'b0, 2'b11, 8'd0, 8'd0, tag);
      end
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 4'(i), base + 8'(i), 2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 8'd0, 8'd0,
               "fill");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //         we    acc   wa     d       re     ra0    ra1    ev     e0      e1
      vecs[0]  = '{1'b1, 1'b0, 4'd3, 8'hA5, 2'b11, 4'd3, 4'd4, 2'b11, 8'hA5, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 4'd0, 8'h00, 2'b10, 4'd0, 4'd3, 2'b10, 8'h00, 8'hA5};
      vecs[2]  = '{1'b1, 1'b0, 4'd7, 8'hF0, 2'b00, 4'd0, 4'd0, 2'b00, 8'h00, 8'h00};
      vecs[3]  = '{1'b1, 1'b1, 4'd7, 8'h20, 2'b01, 4'd7, 4'd0, 2'b01, 8'h10, 8'h00};
      vecs[4]  = '{1'b1, 1'b1, 4'd7, 8'h20, 2'b11, 4'd7, 4'd3, 2'b11, 8'h30, 8'hA5};
      vecs[5]  = '{1'b0, 1'b0, 4'd0, 8'h00, 2'b11, 4'd7, 4'd7, 2'b11, 8'h30, 8'h30};
      vecs[6]  = '{1'b1, 1'b0, 4'd2, 8'h55, 2'b11, 4'd3, 4'd2, 2'b11, 8'hA5, 8'h55};
      vecs[7]  = '{1'b1, 1'b0, 4'd9, 8'h66, 2'b01, 4'd2, 4'd0, 2'b01, 8'h55, 8'h00};
      vecs[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 2'b10, 4'd0, 4'd9, 2'b10, 8'h00, 8'h66};
      vecs[9]  = '{1'b1, 1'b1, 4'd9, 8'h9A, 2'b11, 4'd9, 4'd9, 2'b11, 8'h00, 8'h00};
      vecs[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 2'b00, 8'h00, 8'h00};

      rst       = 1'b1;
      we        = 1'b0;
      acc       = 1'b0;
      wr_addr   = '0;
      din       = '0;
      rd_en     = '0;
      rd_addr   = '0;
      clr_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset clr_busy", {31'd0, clr_busy}, 32'd0);
      check("reset dout_valid", {30'd0, dout_valid}, 32'd0);
      check("reset dout", {16'd0, dout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      read_all_zero("reset readback");

      for (int v = 0; v < 11; v++) begin
         drive(vecs[v].we, vecs[v].acc, vecs[v].wa, vecs[v].d, vecs[v].re, vecs[v].ra0,
               vecs[v].ra1, 1'b0, vecs[v].ev, vecs[v].e0, vecs[v].e1, $sformatf("vec%0d", v));
      end

      // Clear sequence, with a write to entry 5 colliding with clr_start.
      fill(8'h40);
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 4'd15, 4'd0, 1'b0, 2'b01, 8'h4F, 8'd0, "fill check");
      drive(1'b1, 1'b0, 4'd5, 8'h77, 2'b11, 4'd5, 4'd5, 1'b1, 2'b00, 8'd0, 8'd0, "clr_start");
      check("clr_busy after start", {31'd0, clr_busy}, 32'd1);
      n_busy = 0;
      while (clr_busy === 1'b1 && n_busy < 40) begin
         n_busy++;
         drive(1'b1, 1'b1, 4'(n_busy), 8'hFF, 2'b11, 4'(n_busy), 4'd5, n_busy == 8, 2'b00,
               8'd0, 8'd0, "busy");
      end
      check("clr_busy length", n_busy, 32'd16);
      read_all_zero("post clear");

      // Reset in the middle of a clear.
      fill(8'h80);
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b00, 4'd0, 4'd0, 1'b1, 2'b00, 8'd0, 8'd0, "clr_start2");
      repeat (5) idle("busy2");
      check("clr_busy before rst", {31'd0, clr_busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid-clear rst clr_busy", {31'd0, clr_busy}, 32'd0);
      check("mid-clear rst dout_valid", {30'd0, dout_valid}, 32'd0);
      check("mid-clear rst dout", {16'd0, dout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      read_all_zero("post rst");
      drive(1'b1, 1'b0, 4'd6, 8'h3C, 2'b01, 4'd6, 4'd0, 1'b0, 2'b01, 8'h3C, 8'd0, "post rst wr");
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b10, 4'd0, 4'd6, 1'b0, 2'b10, 8'd0, 8'h3C, "post rst rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
